// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: clock glitch filter, 11-bit frame checker and
// E0/F0 prefix folding into a single-entry valid/ready key event register.
module ps2_kbd_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 20000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_kbd_clk,
    input  logic       ps2_kbd_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_released,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam int DLY = FILTER_LEN + 1;
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic [1:0]            clk_sync_reg;
    logic [1:0]            data_sync_reg;
    logic [DLY-1:0]        data_dly_reg;
    logic [FILTER_LEN-1:0] filt_sr_reg;
    logic                  filt_clk_reg;
    logic                  fall_reg;
    logic                  data_bit;

    logic [1:0]    state_reg, state_next;
    logic [2:0]    bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          par_reg, par_next;
    logic [TW-1:0] to_cnt_reg, to_cnt_next;
    logic          ext_reg, ext_next;
    logic          rel_reg, rel_next;
    logic          emit;
    logic          perr_next, ferr_next;

    // Data is delayed by the same number of stages the clock spends in the
    // synchronizer-to-strobe path, so each fall samples the matching bit.
    assign data_bit = data_dly_reg[DLY-1];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            data_dly_reg  <= '1;
            filt_sr_reg   <= '1;
            filt_clk_reg  <= 1'b1;
            fall_reg      <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_kbd_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_kbd_data};
            data_dly_reg  <= {data_dly_reg[DLY-2:0], data_sync_reg[1]};
            filt_sr_reg   <= {filt_sr_reg[FILTER_LEN-2:0], clk_sync_reg[1]};
            if (filt_sr_reg == '0) begin
                filt_clk_reg <= 1'b0;
            end else if (&filt_sr_reg) begin
                filt_clk_reg <= 1'b1;
            end
            fall_reg <= filt_clk_reg && (filt_sr_reg == '0);
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_next     = par_reg;
        to_cnt_next  = to_cnt_reg;
        ext_next     = ext_reg;
        rel_next     = rel_reg;
        emit         = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        if (fall_reg) begin
            to_cnt_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (!data_bit) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                        shift_next   = 8'h00;
                    end
                end
                ST_DATA: begin
                    shift_next   = {data_bit, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_next   = data_bit;
                    state_next = ST_STOP;
                end
                default: begin
                    state_next = ST_IDLE;
                    if (!data_bit) begin
                        ferr_next = 1'b1;
                    end else if ((^{shift_reg, par_reg}) != 1'b1) begin
                        perr_next = 1'b1;
                    end else if (shift_reg == 8'hE0) begin
                        ext_next = 1'b1;
                    end else if (shift_reg == 8'hF0) begin
                        rel_next = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                end
            endcase
        end else if (state_reg != ST_IDLE) begin
            if (to_cnt_reg >= TO_LAST) begin
                to_cnt_next = TO_MAX;
                state_next  = ST_IDLE;
                ferr_next   = 1'b1;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end
        // A discarded frame breaks any prefix sequence in progress.
        if (perr_next || ferr_next || emit) begin
            ext_next = 1'b0;
            rel_next = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= 3'd0;
            shift_reg    <= 8'h00;
            par_reg      <= 1'b0;
            to_cnt_reg   <= '0;
            ext_reg      <= 1'b0;
            rel_reg      <= 1'b0;
            key_valid    <= 1'b0;
            key_code     <= 8'h00;
            key_extended <= 1'b0;
            key_released <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_reg     <= par_next;
            to_cnt_reg  <= to_cnt_next;
            ext_reg     <= ext_next;
            rel_reg     <= rel_next;
            parity_err  <= perr_next;
            frame_err   <= ferr_next;
            overrun     <= 1'b0;
            if (emit) begin
                if (!key_valid || key_ready) begin
                    key_valid    <= 1'b1;
                    key_code     <= shift_reg;
                    key_extended <= ext_reg;
                    key_released <= rel_reg;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus a randomized
// byte stream checked against a prefix-folding reference model.
module tb_ps2_kbd_rx;
    localparam int FL   = 8;
    localparam int TO   = 1500;
    localparam int HALF = 20;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic       ps2_kbd_clk;
    logic       ps2_kbd_data;
    logic       key_valid;
    logic       key_ready;
    logic [7:0] key_code;
    logic       key_extended;
    logic       key_released;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // Monitor state: written only by the monitor processes below.
    int         cyc      = 0;
    int         vld_cnt  = 0;
    int         perr_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;
    int         ferr_cyc = 0;
    int         rx_wr    = 0;
    logic [9:0] rx_mem [256];

    int last_low_cyc = 0;

    ps2_kbd_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ps2_kbd_clk  (ps2_kbd_clk),
        .ps2_kbd_data (ps2_kbd_data),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_extended (key_extended),
        .key_released (key_released),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (key_valid === 1'b1) vld_cnt <= vld_cnt + 1;
        if (key_valid === 1'b1 && key_ready === 1'b1) begin
            rx_mem[rx_wr % 256] <= {key_extended, key_released, key_code};
            rx_wr <= rx_wr + 1;
        end
        if (parity_err === 1'b1) perr_cnt <= perr_cnt + 1;
        if (frame_err === 1'b1) begin
            ferr_cnt <= ferr_cnt + 1;
            ferr_cyc <= cyc;
        end
        if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Sends the first nbits bits of a frame; glitch_at >= 0 inserts a short
    // low pulse on the clock during the high phase of that bit.
    task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad,
                              input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr[0]   = 1'b0;
        fr[8:1] = b;
        fr[9]   = (~(^b)) ^ par_bad;
        fr[10]  = ~stop_bad;
        $display("tx byte=%02h par_bad=%0d stop_bad=%0d bits=%0d glitch=%0d",
                 b, par_bad, stop_bad, nbits, glitch_at);
        for (int i = 0; i < nbits; i++) begin
            ps2_kbd_data = fr[i];
            if (i == glitch_at) begin
                wait_cyc(5);
                ps2_kbd_clk = 1'b0;
                wait_cyc(FL - 1);
                ps2_kbd_clk = 1'b1;
                wait_cyc(HALF - 5 - FL + 1);
            end else begin
                wait_cyc(HALF);
            end
            ps2_kbd_clk  = 1'b0;
            last_low_cyc = cyc;
            wait_cyc(HALF);
            ps2_kbd_clk = 1'b1;
        end
        if (nbits == 11) begin
            ps2_kbd_data = 1'b1;
            wait_cyc(2 * HALF);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(3);
        total += 7;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        if (key_code !== 8'h00) begin bad++; $display("FAIL reset_code got=%h want=00", key_code); end
        if (key_extended !== 1'b0) begin bad++; $display("FAIL reset_ext got=%b want=0", key_extended); end
        if (key_released !== 1'b0) begin bad++; $display("FAIL reset_rel got=%b want=0", key_released); end
        if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b want=0", parity_err); end
        if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b want=0", frame_err); end
        if (overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b want=0", overrun); end
        reset = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_good_frame();
        int s_rx = rx_wr, s_v = vld_cnt, s_p = perr_cnt, s_f = ferr_cnt;
        key_ready = 1'b1;
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        total += 4;
        if (rx_wr - s_rx != 1) begin bad++; $display("FAIL good_count got=%0d want=1", rx_wr - s_rx); end
        else if (rx_mem[s_rx % 256] !== {2'b00, 8'h1C}) begin
            bad++; $display("FAIL good_event got=%h want=%h", rx_mem[s_rx % 256], {2'b00, 8'h1C});
        end
        if (vld_cnt - s_v != 1) begin bad++; $display("FAIL good_valid_cycles got=%0d want=1", vld_cnt - s_v); end
        if (perr_cnt != s_p || ferr_cnt != s_f) begin
            bad++; $display("FAIL good_errors got=%0d/%0d want=0/0", perr_cnt - s_p, ferr_cnt - s_f);
        end
    endtask

    task automatic test_prefix();
        int s_rx = rx_wr;
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h75, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (rx_wr - s_rx != 1) begin bad++; $display("FAIL prefix_count got=%0d want=1", rx_wr - s_rx); end
        else if (rx_mem[s_rx % 256] !== {2'b11, 8'h75}) begin
            bad++; $display("FAIL prefix_event got=%h want=%h", rx_mem[s_rx % 256], {2'b11, 8'h75});
        end
        s_rx = rx_wr;
        send_frame(8'h75, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (rx_wr - s_rx != 1) begin bad++; $display("FAIL prefix_clear_count got=%0d want=1", rx_wr - s_rx); end
        else if (rx_mem[s_rx % 256] !== {2'b00, 8'h75}) begin
            bad++; $display("FAIL prefix_clear_event got=%h want=%h", rx_mem[s_rx % 256], {2'b00, 8'h75});
        end
    endtask

    task automatic test_parity();
        int s_rx = rx_wr, s_p = perr_cnt, s_f = ferr_cnt;
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b1, 1'b0, 11, -1);
        total += 3;
        if (perr_cnt - s_p != 1) begin bad++; $display("FAIL parity_pulse got=%0d want=1", perr_cnt - s_p); end
        if (ferr_cnt != s_f) begin bad++; $display("FAIL parity_no_ferr got=%0d want=0", ferr_cnt - s_f); end
        if (rx_wr != s_rx) begin bad++; $display("FAIL parity_no_event got=%0d want=0", rx_wr - s_rx); end
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (rx_wr - s_rx != 1) begin bad++; $display("FAIL parity_after_count got=%0d want=1", rx_wr - s_rx); end
        else if (rx_mem[s_rx % 256] !== {2'b01, 8'h1C}) begin
            bad++; $display("FAIL parity_after_event got=%h want=%h", rx_mem[s_rx % 256], {2'b01, 8'h1C});
        end
    endtask

    task automatic test_timeout();
        int s_rx = rx_wr, s_f = ferr_cnt, low;
        send_frame(8'h29, 1'b0, 1'b0, 4, -1);
        low = last_low_cyc;
        ps2_kbd_data = 1'b1;
        wait_cyc(TO + 10 + FL + 10);
        total += 2;
        if (ferr_cnt - s_f != 1) begin bad++; $display("FAIL timeout_pulse got=%0d want=1", ferr_cnt - s_f); end
        if (ferr_cyc - low < TO || ferr_cyc - low > TO + FL + 6) begin
            bad++; $display("FAIL timeout_delay got=%0d want=%0d..%0d", ferr_cyc - low, TO, TO + FL + 6);
        end
        send_frame(8'h29, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (rx_wr - s_rx != 1) begin bad++; $display("FAIL timeout_next_count got=%0d want=1", rx_wr - s_rx); end
        else if (rx_mem[s_rx % 256] !== {2'b00, 8'h29}) begin
            bad++; $display("FAIL timeout_next_event got=%h want=%h", rx_mem[s_rx % 256], {2'b00, 8'h29});
        end
    endtask

    task automatic test_overrun();
        int s_rx = rx_wr, s_o = ovr_cnt;
        key_ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        send_frame(8'hF0, 1'b0, 1'b0, 11, -1);
        send_frame(8'h32, 1'b0, 1'b0, 11, -1);
        total += 3;
        if (key_valid !== 1'b1 || key_code !== 8'h1C) begin
            bad++; $display("FAIL overrun_hold got=%b/%h want=1/1c", key_valid, key_code);
        end
        if (ovr_cnt - s_o != 1) begin bad++; $display("FAIL overrun_pulse got=%0d want=1", ovr_cnt - s_o); end
        if (rx_wr != s_rx) begin bad++; $display("FAIL overrun_no_accept got=%0d want=0", rx_wr - s_rx); end
        key_ready = 1'b1;
        wait_cyc(1);
        total += 2;
        if (key_valid !== 1'b0) begin bad++; $display("FAIL overrun_drop got=%b want=0", key_valid); end
        if (rx_wr - s_rx != 1 || rx_mem[s_rx % 256] !== {2'b00, 8'h1C}) begin
            bad++; $display("FAIL overrun_accept got=%0d/%h want=1/%h", rx_wr - s_rx, rx_mem[s_rx % 256], {2'b00, 8'h1C});
        end
        s_rx = rx_wr;
        send_frame(8'h33, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (rx_wr - s_rx != 1 || rx_mem[s_rx % 256] !== {2'b00, 8'h33}) begin
            bad++; $display("FAIL overrun_flags_cleared got=%0d/%h want=1/%h", rx_wr - s_rx, rx_mem[s_rx % 256], {2'b00, 8'h33});
        end
    endtask

    task automatic test_glitch();
        int s_rx = rx_wr, s_p = perr_cnt, s_f = ferr_cnt;
        ps2_kbd_data = 1'b0;
        wait_cyc(3);
        ps2_kbd_clk = 1'b0;
        wait_cyc(FL - 1);
        ps2_kbd_clk = 1'b1;
        wait_cyc(3);
        ps2_kbd_data = 1'b1;
        wait_cyc(2 * HALF);
        send_frame(8'h5B, 1'b0, 1'b0, 11, 4);
        total += 2;
        if (rx_wr - s_rx != 1 || rx_mem[s_rx % 256] !== {2'b00, 8'h5B}) begin
            bad++; $display("FAIL glitch_event got=%0d/%h want=1/%h", rx_wr - s_rx, rx_mem[s_rx % 256], {2'b00, 8'h5B});
        end
        if (perr_cnt != s_p || ferr_cnt != s_f) begin
            bad++; $display("FAIL glitch_errors got=%0d/%0d want=0/0", perr_cnt - s_p, ferr_cnt - s_f);
        end
    endtask

    task automatic test_reset_mid();
        int s_rx, s_p, s_f;
        key_ready = 1'b0;
        send_frame(8'h1C, 1'b0, 1'b0, 11, -1);
        send_frame(8'hE0, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (key_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pre_valid got=%b want=1", key_valid); end
        send_frame(8'h5A, 1'b0, 1'b0, 5, -1);
        s_p = perr_cnt;
        s_f = ferr_cnt;
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(1);
        total += 2;
        if (key_valid !== 1'b0 || key_code !== 8'h00 || key_extended !== 1'b0 || key_released !== 1'b0) begin
            bad++; $display("FAIL rstmid_outputs got=%b/%h/%b/%b want=0/00/0/0", key_valid, key_code, key_extended, key_released);
        end
        ps2_kbd_data = 1'b1;
        key_ready = 1'b1;
        wait_cyc(4 * HALF);
        if (perr_cnt != s_p || ferr_cnt != s_f) begin
            bad++; $display("FAIL rstmid_no_error got=%0d/%0d want=0/0", perr_cnt - s_p, ferr_cnt - s_f);
        end
        s_rx = rx_wr;
        send_frame(8'h5A, 1'b0, 1'b0, 11, -1);
        total += 1;
        if (rx_wr - s_rx != 1 || rx_mem[s_rx % 256] !== {2'b00, 8'h5A}) begin
            bad++; $display("FAIL rstmid_next got=%0d/%h want=1/%h", rx_wr - s_rx, rx_mem[s_rx % 256], {2'b00, 8'h5A});
        end
    endtask

    // Reference model: prefixes accumulate, any error forgets them, any other
    // good byte becomes an event carrying the accumulated prefixes.
    task automatic test_random();
        logic [9:0] exp_q[$];
        logic [7:0] b;
        bit ext = 0, rel = 0, pb, sb;
        int exp_p = 0, exp_f = 0, r;
        int s_rx = rx_wr, s_p = perr_cnt, s_f = ferr_cnt;
        key_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 99);
            if (r < 25) b = 8'hE0;
            else if (r < 45) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 99);
            pb = (r < 12);
            sb = (r >= 12 && r < 20);
            send_frame(b, pb, sb, 11, -1);
            if (sb) begin exp_f++; ext = 0; rel = 0; end
            else if (pb) begin exp_p++; ext = 0; rel = 0; end
            else if (b == 8'hE0) ext = 1;
            else if (b == 8'hF0) rel = 1;
            else begin exp_q.push_back({ext, rel, b}); ext = 0; rel = 0; end
        end
        total += 3;
        if (rx_wr - s_rx != exp_q.size()) begin
            bad++; $display("FAIL random_count got=%0d want=%0d", rx_wr - s_rx, exp_q.size());
        end
        if (perr_cnt - s_p != exp_p) begin bad++; $display("FAIL random_perr got=%0d want=%0d", perr_cnt - s_p, exp_p); end
        if (ferr_cnt - s_f != exp_f) begin bad++; $display("FAIL random_ferr got=%0d want=%0d", ferr_cnt - s_f, exp_f); end
        for (int k = 0; k < exp_q.size() && k < rx_wr - s_rx; k++) begin
            total++;
            if (rx_mem[(s_rx + k) % 256] !== exp_q[k]) begin
                bad++; $display("FAIL random_event%0d got=%h want=%h", k, rx_mem[(s_rx + k) % 256], exp_q[k]);
            end
        end
    endtask

    initial begin
        ps2_kbd_clk  = 1'b1;
        ps2_kbd_data = 1'b1;
        key_ready    = 1'b1;
        reset        = 1'b1;
        test_reset();
        test_good_frame();
        test_prefix();
        test_parity();
        test_timeout();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_kbd_rx.md
Name: ps2_kbd_rx

Overview:
Receives the PS/2 keyboard stream produced by the user_io keyboard emulation (ps2_kbd_clk / ps2_kbd_data) and turns it into key events inside the core, all on clk_sys. Three stages:
- glitch filter on the PS/2 clock;
- 11-bit frame receiver with parity, stop-bit and timeout checks;
- prefix decoder that folds E0/F0 prefixes into flags on a single-entry valid/ready event register.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronized ps2_kbd_clk samples needed to change the filtered clock level.
TIMEOUT, 20000, clk_sys cycles allowed between filtered falling edges inside a frame before the frame is aborted.

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_kbd_clk  in  1  PS/2 clock from user_io; idles high
ps2_kbd_data  in  1  PS/2 data from user_io; sampled on filtered falling edge
key_valid  out  1  key event available; held until accepted
key_ready  in  1  consumer accepts event when key_valid & key_ready
key_code  out  8  scancode of event, excluding prefixes
key_extended  out  1  E0 prefix preceded this code
key_released  out  1  F0 prefix preceded this code
parity_err  out  1  one-cycle pulse: frame discarded, bad parity
frame_err  out  1  one-cycle pulse: frame discarded, bad stop bit or timeout
overrun  out  1  one-cycle pulse: event dropped because key_valid & ~key_ready

Behaviour:
- Reset (synchronous, active-high, clk_sys) clears everything:
  - outputs key_valid, key_code, key_extended, key_released, parity_err, frame_err, overrun all 0;
  - FSM to IDLE, prefix flags 0, filter shift register all 1s, filtered clock 1, timeout counter 0;
  - reset mid-frame discards the partial frame with no error pulse.
- Input path: both inputs pass through 2-FF synchronizers. Data is delayed to match clock filter latency.
- Clock filter:
  - FILTER_LEN-deep shift register of synchronized clock;
  - filtered clock goes 0 when all bits are 0, goes 1 when all bits are 1, otherwise holds;
  - fall = registered one-cycle strobe on the filtered 1->0 transition.
- Frame FSM (advances only on fall):
  - IDLE: data 0 → DATA, bit count 0, shift register cleared. Data 1 → stay IDLE; false start, no error.
  - DATA: shift data in LSB first; after the 8th bit → PARITY.
  - PARITY: store bit → STOP.
  - STOP:
    - data 0 → frame_err;
    - else XOR(8 data bits, parity bit) must be 1 (odd parity), otherwise parity_err;
    - else byte goes to the decoder;
    - always → IDLE.
- Timeout:
  - counter clears on every fall and counts while FSM ≠ IDLE;
  - reaching TIMEOUT → frame_err pulse, IDLE, shift register discarded.
- Any parity_err or frame_err also clears both prefix flags.
- Decoder, on a good byte B:
  - B = E0: set ext flag, no event;
  - B = F0: set rel flag, no event;
  - any other B (including E1, AA, FA) emits an event {B, ext, rel} and clears both flags.
- Event register:
  - emitting while key_valid=0, or key_valid=1 with key_ready=1 in the same cycle: load key_code/key_extended/key_released and set key_valid;
  - emitting while key_valid=1 and key_ready=0: keep the old event, pulse overrun, drop the new one (its flags still clear);
  - key_valid & key_ready with no new event: key_valid → 0 next cycle; data outputs hold their last value.
- Latency: fall strobe sampling the stop bit in cycle N → key_valid and error pulses registered high in cycle N+1.
- Error and overrun pulses last exactly one cycle. Several may coincide only if independent; no pulse is stretched.
- Widths: bit count 3 bits. Timeout counter sized $clog2(TIMEOUT+1) and saturates at TIMEOUT.

Test Plan:
- Good frame: user_io-style frame for 0x1C (start 0, bits LSB first, parity 0, stop 1), key_ready=1 → one key_valid pulse with key_code=1C, key_extended=0, key_released=0, no error pulses.
- Prefix folding: frames E0, F0, 75 → exactly one event, code=75, ext=1, rel=1. Next frame 75 → event with ext=0, rel=0.
- Bad parity: frame 0x1C with parity bit 1 → parity_err pulse, no event. Following frames F0 then 1C → event rel=1, proving flags cleared only by the error, not lost afterward.
- Timeout: start bit plus 3 data bits, then clock held high for TIMEOUT+10 cycles → frame_err pulse TIMEOUT cycles after the last fall. Next complete 0x29 frame → code=29.
- Overrun and glitch:
  - key_ready=0, send 1C then 32 → key_code stays 1C, overrun pulse on second event; key_ready=1 → key_valid drops next cycle.
  - a 0-glitch of FILTER_LEN-1 cycles on ps2_kbd_clk → no bit sampled.
- Reset mid-frame: reset during bit 4 of a frame → all outputs 0, no error pulse. Next full 0x5A frame → code=5A.
